vadd_arbiter: RTL and testbench

Round-robin arbiter that shares one vector-add datapath among NREQ requesters. It grants one requester at a time, drives the datapath's start pulse and operand-select index, and waits for the datapath's done flag. It then returns a per-requester completion or timeout pulse. It sits between the client request logic and the vector adder plus its operand muxes, which are external and steered by `add_sel`.

---
 rtl/vadd_arbiter.sv | 112 +++++++++++
 tb/tb_vadd_arbiter.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/vadd_arbiter.sv
// Round-robin arbiter sharing one vector-add datapath among NREQ requesters.
// Grants one owner at a time, pulses add_start, waits for a done rising edge or timeout.
module vadd_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 32,
    parameter int IDW     = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] grant,
    output logic [NREQ-1:0] resp_done,
    output logic [NREQ-1:0] resp_err,
    output logic            add_start,
    output logic [IDW-1:0]  add_sel,
    input  logic            add_done,
    output logic            busy,
    output logic [7:0]      err_cnt
);
    typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

    state_t         state, state_n;
    logic [IDW-1:0] ptr, pick, cand;
    logic           found;
    logic [7:0]     wcnt;
    logic           done_q, done_rise;
    logic           outcome_ok, ok_n, tmo;
    logic           in_resp;

    // first requester at or after ptr, wrapping
    always_comb begin
        pick  = '0;
        cand  = '0;
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            cand = IDW'((int'(ptr) + i) % NREQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    // only a fresh edge counts; a level left over from the last op is ignored
    assign done_rise = add_done & ~done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        ok_n    = outcome_ok;
        tmo     = 1'b0;
        case (state)
            IDLE:  if (found) state_n = START;
            START: state_n = WAIT;
            WAIT: begin
                if (done_rise) begin
                    state_n = RESP;
                    ok_n    = 1'b1;
                end else if (wcnt == 8'(TIMEOUT - 1)) begin
                    state_n = RESP;
                    ok_n    = 1'b0;
                    tmo     = 1'b1;
                end
            end
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant      <= '0;
            add_sel    <= '0;
            ptr        <= '0;
            wcnt       <= '0;
            done_q     <= 1'b0;
            outcome_ok <= 1'b0;
            err_cnt    <= '0;
        end else begin
            done_q     <= add_done;
            outcome_ok <= ok_n;
            if (tmo && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            case (state)
                IDLE: if (found) begin
                    grant   <= NREQ'(1) << pick;
                    add_sel <= pick;
                end
                START: wcnt <= '0;
                WAIT:  if (state_n == WAIT) wcnt <= wcnt + 8'd1;
                RESP: begin
                    grant <= '0;
                    ptr   <= (add_sel == IDW'(NREQ - 1)) ? '0 : add_sel + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign add_start = (state == START);
    assign busy      = (state != IDLE);
    assign in_resp   = (state == RESP);

    for (genvar g = 0; g < NREQ; g++) begin : g_resp
        assign resp_done[g] = in_resp &  outcome_ok & grant[g];
        assign resp_err[g]  = in_resp & ~outcome_ok & grant[g];
    end

endmodule

// File: tb/tb_vadd_arbiter.sv
// Bench for vadd_arbiter: directed + random operations against a transaction-level model
// (rotating owner choice, response offset from add_start, saturating timeout count).
module tb_vadd_arbiter;
    localparam int NREQ    = 4;
    localparam int TIMEOUT = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic [NREQ-1:0] req = '0;
    logic [NREQ-1:0] grant, resp_done, resp_err;
    logic            add_start, busy;
    logic [1:0]      add_sel;
    logic            add_done = 1'b0;
    logic [7:0]      err_cnt;

    int checks = 0;
    int errors = 0;
    int m_ptr  = 0;
    int m_err  = 0;
    int lat_cfg = 0;
    int dcnt = 0;

    vadd_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .grant(grant),
        .resp_done(resp_done), .resp_err(resp_err), .add_start(add_start),
        .add_sel(add_sel), .add_done(add_done), .busy(busy), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    // adder: done drops when start is accepted and rises lat_cfg edges later (0 = never)
    always @(posedge clk) begin
        if (add_start) begin
            add_done <= 1'b0;
            dcnt     <= lat_cfg;
        end else if (dcnt > 0) begin
            dcnt <= dcnt - 1;
            if (dcnt == 1) add_done <= 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // one full operation; returns at the negedge of the IDLE cycle after RESP
    task automatic do_op(input logic [3:0] r, input int lat, input bit drop);
        int own, off, k;
        bit ok;
        logic [3:0] oh;
        own = -1;
        for (int i = 0; i < NREQ; i++) begin
            k = (m_ptr + i) % NREQ;
            if (own < 0 && ((r >> k) & 4'd1) != 4'd0) own = k;
        end
        oh  = 4'(1 << own);
        ok  = (lat != 0) && (lat + 1 <= TIMEOUT);
        off = ok ? lat + 2 : TIMEOUT + 1;
        lat_cfg = lat;
        req = r;
        @(posedge clk); @(negedge clk);
        chk("start_pulse", add_start, 1);
        chk("grant", grant, oh);
        chk("add_sel", add_sel, own);
        chk("busy", busy, 1);
        chk("start_no_resp", resp_done | resp_err, 0);
        if (drop) req = '0;
        for (int c = 1; c <= off; c++) begin
            @(negedge clk);
            chk("add_start_low", add_start, 0);
            chk("grant_hold", grant, oh);
            chk("sel_hold", add_sel, own);
            chk("grant_onehot", $onehot0(grant), 1);
            if (c == off) begin
                if (!ok && m_err < 255) m_err++;
                chk("resp_done", resp_done, ok ? oh : 4'd0);
                chk("resp_err", resp_err, ok ? 4'd0 : oh);
            end else begin
                chk("no_early_resp", resp_done | resp_err, 0);
            end
            chk("err_cnt", err_cnt, m_err);
        end
        @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_grant", grant, 0);
        chk("idle_resp", resp_done | resp_err, 0);
        m_ptr = (own + 1) % NREQ;
    endtask

    initial begin
        logic [3:0] r;
        int lat;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_start", add_start, 0);
        chk("rst_sel", add_sel, 0);
        chk("rst_err_cnt", err_cnt, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_resp", resp_done | resp_err, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_no_req", busy, 0);

        // fairness: all requesting, expect owners 0,1,2,3,0 (ops after the first start with stale done high)
        for (int i = 0; i < 5; i++) do_op(4'b1111, 9, 1'b0);
        req = '0;
        do_op(4'b0010, 9, 1'b0);
        // timeout, then coincidence boundary on both sides
        do_op(4'b0001, 0, 1'b1);
        do_op(4'b0100, TIMEOUT - 1, 1'b1);
        do_op(4'b0100, TIMEOUT, 1'b1);

        for (int i = 0; i < 40; i++) begin
            r   = 4'($urandom_range(1, 15));
            lat = $urandom_range(0, 40);
            do_op(r, lat, 1'($urandom_range(0, 1)));
        end

        // reset while an operation is waiting
        lat_cfg = 0;
        req = 4'b0100;
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_grant", grant, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_start", add_start, 0);
        chk("mid_rst_sel", add_sel, 0);
        chk("mid_rst_err_cnt", err_cnt, 0);
        chk("mid_rst_resp", resp_done | resp_err, 0);
        req = '0;
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
        m_ptr = 0;
        m_err = 0;
        @(negedge clk);
        do_op(4'b1010, 9, 1'b1);
        do_op(4'b1000, 9, 1'b1);

        // saturation of the timeout counter
        for (int i = 0; i < 300; i++) do_op(4'($urandom_range(1, 15)), 0, 1'b1);
        chk("err_cnt_sat", err_cnt, 255);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
